// File: rtl/demixer.sv
// demixer: drains one merged 9-bit ingress FIFO and steers each frame to the
// port0..3, arp and nic egress FIFOs according to the destination mask carried
// in the frame's header byte. The header itself is consumed.
// Optional statistics counters (stat_tx/stat_drop/stat_trunc) exist only when
// the DEMIXER_STATS_EN macro is defined.
module demixer #(
  parameter int MAX_LEN   = 1522,
  parameter int LEN_WIDTH = 11
`ifdef DEMIXER_STATS_EN
  ,
  parameter int CNT_WIDTH = 32
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [8:0] in_dout,
  input  logic       in_empty,
  output logic       in_rd_en,
  output logic [8:0] port0_din,
  input  logic       port0_full,
  output logic       port0_wr_en,
  output logic [8:0] port1_din,
  input  logic       port1_full,
  output logic       port1_wr_en,
  output logic [8:0] port2_din,
  input  logic       port2_full,
  output logic       port2_wr_en,
  output logic [8:0] port3_din,
  input  logic       port3_full,
  output logic       port3_wr_en,
  output logic [8:0] arp_din,
  input  logic       arp_full,
  output logic       arp_wr_en,
  output logic [8:0] nic_din,
  input  logic       nic_full,
  output logic       nic_wr_en
`ifdef DEMIXER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_tx,
  output logic [CNT_WIDTH-1:0] stat_drop,
  output logic [CNT_WIDTH-1:0] stat_trunc
`endif
);

  // IDLE: nothing outstanding. HDR: the byte returning now is a header.
  // FWD: returning bytes are forwarded. DROP: returning bytes are discarded.
  typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

  state_t               state_reg, state_next;
  state_t               after_eof;
  logic [5:0]           mask_reg, mask_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic                 rd_valid_reg;
  logic [8:0]           dout_reg, dout_next;
  logic [5:0]           wr_en_reg, wr_en_next;
  logic [5:0]           full_vec;
  logic                 stall;
  logic                 rd_en;
  logic                 last_slot;

  // Bit order matches the header mask: {nic, arp, port3, port2, port1, port0}.
  assign full_vec = {nic_full, arp_full, port3_full, port2_full, port1_full, port0_full};

  // Only a forwarding frame can be held up by a full destination.
  assign stall = (state_reg == FWD) && (|(full_vec & mask_reg));

  // IDLE never has a read outstanding (a frame end with a read issued in the
  // same cycle goes straight to HDR), so at most one header is ever in flight.
  assign rd_en    = !sys_rst && !in_empty && !stall;
  assign in_rd_en = rd_en;

  // The byte now returning is the MAX_LEN-th payload byte of the frame.
  assign last_slot = (len_reg == LEN_WIDTH'(MAX_LEN - 1));

  // A read issued alongside a frame end returns the next frame's header.
  assign after_eof = rd_en ? HDR : IDLE;

  // Next-state, mask/length tracking and egress write generation.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    len_next   = len_reg;
    dout_next  = dout_reg;
    wr_en_next = '0;
    case (state_reg)
      IDLE: begin
        if (rd_en) state_next = HDR;
      end
      HDR: begin
        if (rd_valid_reg) begin
          mask_next = in_dout[5:0];
          len_next  = '0;
          if (in_dout[8])                state_next = after_eof;
          else if (in_dout[5:0] == 6'd0) state_next = DROP;
          else                           state_next = FWD;
        end
      end
      FWD: begin
        if (rd_valid_reg) begin
          dout_next  = in_dout;
          wr_en_next = mask_reg;
          len_next   = len_reg + 1'b1;
          if (in_dout[8]) begin
            state_next = after_eof;
          end else if (last_slot) begin
            dout_next[8] = 1'b1;
            state_next   = DROP;
          end
        end
      end
      DROP: begin
        if (rd_valid_reg && in_dout[8]) state_next = after_eof;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, read-pipeline and registered egress outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg    <= IDLE;
      mask_reg     <= '0;
      len_reg      <= '0;
      rd_valid_reg <= 1'b0;
      dout_reg     <= '0;
      wr_en_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      mask_reg     <= mask_next;
      len_reg      <= len_next;
      rd_valid_reg <= rd_en;
      dout_reg     <= dout_next;
      wr_en_reg    <= wr_en_next;
    end
  end

  // All egress ports share one data register; only write enables differ.
  assign port0_din   = dout_reg;
  assign port1_din   = dout_reg;
  assign port2_din   = dout_reg;
  assign port3_din   = dout_reg;
  assign arp_din     = dout_reg;
  assign nic_din     = dout_reg;
  assign port0_wr_en = wr_en_reg[0];
  assign port1_wr_en = wr_en_reg[1];
  assign port2_wr_en = wr_en_reg[2];
  assign port3_wr_en = wr_en_reg[3];
  assign arp_wr_en   = wr_en_reg[4];
  assign nic_wr_en   = wr_en_reg[5];

`ifdef DEMIXER_STATS_EN
  logic [2:0]                evt;
  logic [2:0][CNT_WIDTH-1:0] stat_vec;

  // evt[0]: EOF written (including forced), evt[1]: frame dropped, evt[2]: forced EOF.
  assign evt[0] = (state_reg == FWD) && rd_valid_reg && (in_dout[8] || last_slot);
  assign evt[1] = (state_reg == HDR) && rd_valid_reg && (in_dout[8] || (in_dout[5:0] == 6'd0));
  assign evt[2] = (state_reg == FWD) && rd_valid_reg && !in_dout[8] && last_slot;

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [CNT_WIDTH-1:0] cnt_reg;
    // Saturating event counter; holds at all-ones instead of wrapping.
    always_ff @(posedge sys_clk) begin
      if (sys_rst)                          cnt_reg <= '0;
      else if (evt[gi] && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;
    end
    assign stat_vec[gi] = cnt_reg;
  end

  assign stat_tx    = stat_vec[0];
  assign stat_drop  = stat_vec[1];
  assign stat_trunc = stat_vec[2];
`endif

endmodule
